// File: rtl/seq_mag_comparator_if.sv
// Operand-load, compare-request and result signals of the sequential
// magnitude comparator, grouped so the block can be wired with one port.
interface seq_mag_comparator_if #(
  parameter int WIDTH = 8,
  parameter int NSEL  = (WIDTH / 4 > 1) ? $clog2(WIDTH / 4) : 1
);
  // Requests from the push-button side
  logic            load;
  logic            op_sel;
  logic [NSEL-1:0] nib_sel;
  logic [3:0]      Y;
  logic            start;
  logic            signed_mode;

  // Comparison results
  logic            l;
  logic            g;
  logic            e;
  logic            valid;
  logic            busy;

  modport master (
    output load, op_sel, nib_sel, Y, start, signed_mode,
    input  l, g, e, valid, busy
  );

  modport slave (
    input  load, op_sel, nib_sel, Y, start, signed_mode,
    output l, g, e, valid, busy
  );
endinterface

// File: rtl/seq_mag_comparator.sv
// Bit-serial magnitude comparator. Operands A and B are built a nibble at a
// time from push-button loads; a start press snapshots both operands and
// walks them MSB first, one bit per clock, until a difference (or the LSB)
// decides l/g/e.
module seq_mag_comparator #(
  parameter int WIDTH = 8,
  parameter int NSEL  = (WIDTH / 4 > 1) ? $clog2(WIDTH / 4) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_mag_comparator_if.slave  bus
);

  localparam int NNIB = WIDTH / 4;
  localparam int IW   = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_DONE
  } state_e;

  // Button synchronisers, previous-value flops and post-reset arming
  logic       ld_s1_q, ld_s1_d, ld_s2_q, ld_s2_d, ld_prev_q, ld_prev_d;
  logic       st_s1_q, st_s1_d, st_s2_q, st_s2_d, st_prev_q, st_prev_d;
  logic       ld_arm_q, ld_arm_d, st_arm_q, st_arm_d;
  logic [1:0] fill_q, fill_d;
  logic       ld_edge, st_edge;

  // Live operands and the snapshot being compared
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] a_snap_q, a_snap_d, b_snap_q, b_snap_d;
  logic             smode_q, smode_d;
  logic [IW-1:0]    idx_q, idx_d;

  // Control and results
  state_e state_q, state_d;
  logic   l_q, l_d, g_q, g_d, e_q, e_d;
  logic   valid_q, valid_d, busy_q, busy_d;

  logic   bit_a, bit_b, at_msb, a_wins;

  // A button held through reset must not count as a press: the chain is
  // only armed once it has seen a genuine post-reset low sample. fill_q
  // marks when the synchroniser holds real samples rather than reset zeros.
  assign ld_edge = ld_s2_q & ~ld_prev_q & ld_arm_q;
  assign st_edge = st_s2_q & ~st_prev_q & st_arm_q;

  // Synchroniser chains, previous-value flops and arming
  always_comb begin
    ld_s1_d   = bus.load;
    ld_s2_d   = ld_s1_q;
    ld_prev_d = ld_s2_q;
    st_s1_d   = bus.start;
    st_s2_d   = st_s1_q;
    st_prev_d = st_s2_q;
    fill_d    = {fill_q[0], 1'b1};
    ld_arm_d  = ld_arm_q | (fill_q[1] & ~ld_s2_q);
    st_arm_d  = st_arm_q | (fill_q[1] & ~st_s2_q);
  end

  // Nibble writes into A or B; an index with no matching nibble writes nothing
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    a_d = a_q;
    b_d = b_q;
    if (ld_edge) begin
      for (int n = 0; n < NNIB; n++) begin
        if (int'(bus.nib_sel) == n) begin
          if (bus.op_sel) b_d[4*n +: 4] = bus.Y;
          else            a_d[4*n +: 4] = bus.Y;
        end
      end
    end
  end

  assign bit_a  = a_snap_q[idx_q];
  assign bit_b  = b_snap_q[idx_q];
  assign at_msb = (idx_q == IW'(WIDTH - 1));
  // In two's complement the sign bit has the opposite weight
  assign a_wins = bit_a ^ (smode_q & at_msb);

  // Comparator FSM: next state, snapshot, bit index and result
  always_comb begin
    state_d  = state_q;
    a_snap_d = a_snap_q;
    b_snap_d = b_snap_q;
    smode_d  = smode_q;
    idx_d    = idx_q;
    l_d      = l_q;
    g_d      = g_q;
    e_d      = e_q;
    valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (st_edge) begin
          // Snapshot the pre-write operands even if a load lands this cycle
          a_snap_d = a_q;
          b_snap_d = b_q;
          smode_d  = bus.signed_mode;
          idx_d    = IW'(WIDTH - 1);
          state_d  = S_CMP;
        end
      end
      S_CMP: begin
        if (bit_a != bit_b) begin
          g_d     = a_wins;
          l_d     = ~a_wins;
          e_d     = 1'b0;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - IW'(1);
        end else begin
          g_d     = 1'b0;
          l_d     = 1'b0;
          e_d     = 1'b1;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Start presses outside IDLE fall through the case untouched: dropped
    busy_d = (state_d != S_IDLE);
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      ld_s1_q   <= 1'b0;
      ld_s2_q   <= 1'b0;
      ld_prev_q <= 1'b0;
      st_s1_q   <= 1'b0;
      st_s2_q   <= 1'b0;
      st_prev_q <= 1'b0;
      ld_arm_q  <= 1'b0;
      st_arm_q  <= 1'b0;
      fill_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      a_snap_q  <= '0;
      b_snap_q  <= '0;
      smode_q   <= 1'b0;
      idx_q     <= '0;
      state_q   <= S_IDLE;
      l_q       <= 1'b0;
      g_q       <= 1'b0;
      e_q       <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ld_s1_q   <= ld_s1_d;
      ld_s2_q   <= ld_s2_d;
      ld_prev_q <= ld_prev_d;
      st_s1_q   <= st_s1_d;
      st_s2_q   <= st_s2_d;
      st_prev_q <= st_prev_d;
      ld_arm_q  <= ld_arm_d;
      st_arm_q  <= st_arm_d;
      fill_q    <= fill_d;
      a_q       <= a_d;
      b_q       <= b_d;
      a_snap_q  <= a_snap_d;
      b_snap_q  <= b_snap_d;
      smode_q   <= smode_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
      l_q       <= l_d;
      g_q       <= g_d;
      e_q       <= e_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.l     = l_q;
  assign bus.g     = g_q;
  assign bus.e     = e_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench for seq_mag_comparator: an 8-bit and a 16-bit instance
// share one set of button/data drivers; use16 selects whose outputs are
// compared. Inputs change and outputs are sampled on the falling edge.
module tb_seq_mag_comparator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       ld, st, op, sm;
  logic [1:0] nib;
  logic [3:0] y;
  logic       use16;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mag_comparator_if #(.WIDTH(8))  bus8 ();
  seq_mag_comparator_if #(.WIDTH(16)) bus16 ();

  assign bus8.load         = ld;
  assign bus8.op_sel       = op;
  assign bus8.nib_sel      = nib[0:0];
  assign bus8.Y            = y;
  assign bus8.start        = st;
  assign bus8.signed_mode  = sm;
  assign bus16.load        = ld;
  assign bus16.op_sel      = op;
  assign bus16.nib_sel     = nib;
  assign bus16.Y           = y;
  assign bus16.start       = st;
  assign bus16.signed_mode = sm;

  seq_mag_comparator #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  seq_mag_comparator #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  logic       o_l, o_g, o_e, o_valid, o_busy;
  logic [2:0] o_lge;
  assign o_l     = use16 ? bus16.l     : bus8.l;
  assign o_g     = use16 ? bus16.g     : bus8.g;
  assign o_e     = use16 ? bus16.e     : bus8.e;
  assign o_valid = use16 ? bus16.valid : bus8.valid;
  assign o_busy  = use16 ? bus16.busy  : bus8.busy;
  assign o_lge   = {o_l, o_g, o_e};

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One load press: write lands two edges after the first sampling edge
  task automatic load_nib(input logic o, input logic [1:0] n, input logic [3:0] v);
    op  = o;
    nib = n;
    y   = v;
    ld  = 1'b1;
    repeat (3) cycle();
    ld = 1'b0;
    repeat (3) cycle();
  endtask

  // One start press and the full result sequence.
  // mode 0: plain; 1: load press during CMP; 2: second start press during
  // CMP; 3: load press in the same cycle as the start press.
  task automatic do_compare(input string tag, input logic s_mode,
                            input logic [2:0] exp_lge, input int exp_lat,
                            input int mode, input logic l_op,
                            input logic [1:0] l_nib, input logic [3:0] l_y);
    int w;
    int lat;
    int pulses;
    logic found;
    w     = use16 ? 16 : 8;
    sm    = s_mode;
    st    = 1'b1;
    if (mode == 3) begin
      op  = l_op;
      nib = l_nib;
      y   = l_y;
      ld  = 1'b1;
    end
    cycle();                                   // edge k
    check({tag, "_busy_k"}, 32'(o_busy), 0);
    cycle();                                   // edge k+1
    check({tag, "_busy_k1"}, 32'(o_busy), 0);
    st = 1'b0;
    if (mode == 3) ld = 1'b0;
    cycle();                                   // edge k+2: accept
    check({tag, "_busy_acc"}, 32'(o_busy), 1);
    lat   = 0;
    found = 1'b0;
    while (!found && lat < w + 4) begin
      if (mode == 1 && lat == 1) begin
        op  = l_op;
        nib = l_nib;
        y   = l_y;
        ld  = 1'b1;
      end
      if (mode == 1 && lat == 4) ld = 1'b0;
      if (mode == 2 && lat == 2) st = 1'b1;
      if (mode == 2 && lat == 5) st = 1'b0;
      cycle();
      lat++;
      if (o_valid) found = 1'b1;
    end
    ld = 1'b0;
    st = 1'b0;
    check({tag, "_valid_seen"}, 32'(found), 1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_lge"}, 32'(o_lge), 32'(exp_lge));
    check({tag, "_busy_done"}, 32'(o_busy), 1);
    cycle();
    check({tag, "_valid_1cyc"}, 32'(o_valid), 0);
    check({tag, "_busy_idle"}, 32'(o_busy), 0);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      if (o_valid) pulses++;
    end
    check({tag, "_extra_valid"}, 32'(pulses), 0);
    check({tag, "_lge_hold"}, 32'(o_lge), 32'(exp_lge));
  endtask

  initial begin
    int   pulses;
    logic seen;
    reset = 1'b1;
    ld    = 1'b0;
    st    = 1'b0;
    op    = 1'b0;
    sm    = 1'b0;
    nib   = '0;
    y     = '0;
    use16 = 1'b0;

    // Reset state
    repeat (3) cycle();
    check("rst_lge",   32'(o_lge),   0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_busy",  32'(o_busy),  0);

    // Start button held through reset release: no comparison may begin
    st = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (o_busy || o_valid) seen = 1'b1;
    end
    check("held_start_no_edge", 32'(seen), 0);
    st = 1'b0;
    repeat (4) cycle();

    // A = B = 0x5A -> equal after walking all 8 bits
    load_nib(1'b0, 2'd0, 4'hA);
    load_nib(1'b0, 2'd1, 4'h5);
    load_nib(1'b1, 2'd0, 4'hA);
    load_nib(1'b1, 2'd1, 4'h5);
    do_compare("eq_5a", 1'b0, EQ, 8, 0, 1'b0, 2'd0, 4'h0);

    // Load A[3:0]=0 together with start: snapshot still sees 0x5A == 0x5A
    do_compare("ld_with_start", 1'b0, EQ, 8, 3, 1'b0, 2'd0, 4'h0);
    // Now A = 0x50, B = 0x5A: first difference at bit 3 -> l, 5 cycles
    do_compare("lt_50_5a", 1'b0, LT, 5, 0, 1'b0, 2'd0, 4'h0);

    // A = 0x80, B = 0x7F: unsigned g, signed l, decided at the MSB
    load_nib(1'b0, 2'd1, 4'h8);
    load_nib(1'b0, 2'd0, 4'h0);
    load_nib(1'b1, 2'd1, 4'h7);
    load_nib(1'b1, 2'd0, 4'hF);
    do_compare("gt_80_7f_uns", 1'b0, GT, 1, 0, 1'b0, 2'd0, 4'h0);
    do_compare("lt_80_7f_sgn", 1'b1, LT, 1, 0, 1'b0, 2'd0, 4'h0);

    // A = 0x12, B = 0x13: l at the LSB; a second start while busy is dropped
    load_nib(1'b0, 2'd1, 4'h1);
    load_nib(1'b0, 2'd0, 4'h2);
    load_nib(1'b1, 2'd1, 4'h1);
    load_nib(1'b1, 2'd0, 4'h3);
    do_compare("lt_12_13_drop", 1'b0, LT, 8, 2, 1'b0, 2'd0, 4'h0);

    // Reset while in CMP with bit index 4 aborts the comparison
    sm = 1'b0;
    st = 1'b1;
    cycle();
    cycle();
    st = 1'b0;
    cycle();                                   // accept, index 7
    repeat (3) cycle();                        // index 6, 5, 4
    check("abort_busy_before", 32'(o_busy), 1);
    reset = 1'b1;
    cycle();
    check("abort_lge",   32'(o_lge),   0);
    check("abort_valid", 32'(o_valid), 0);
    check("abort_busy",  32'(o_busy),  0);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (o_valid) pulses++;
    end
    check("abort_no_valid", 32'(pulses), 0);
    // Operands were cleared by reset: 0 == 0
    do_compare("after_abort_eq", 1'b0, EQ, 8, 0, 1'b0, 2'd0, 4'h0);

    // A = 0x00, B = 0x01; B[7:4] <= F during the comparison
    load_nib(1'b1, 2'd0, 4'h1);
    do_compare("snap_lt_00_01", 1'b0, LT, 8, 1, 1'b1, 2'd1, 4'hF);
    // B must now hold 0xF1: A = 0xF1 compares equal
    load_nib(1'b0, 2'd1, 4'hF);
    load_nib(1'b0, 2'd0, 4'h1);
    do_compare("b_is_f1", 1'b0, EQ, 8, 0, 1'b0, 2'd0, 4'h0);

    // 16-bit instance: A = 0x8000, B = 0x0001
    use16 = 1'b1;
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    repeat (4) cycle();
    load_nib(1'b0, 2'd3, 4'h8);
    load_nib(1'b1, 2'd0, 4'h1);
    do_compare("w16_lt_sgn", 1'b1, LT, 1, 0, 1'b0, 2'd0, 4'h0);
    do_compare("w16_gt_uns", 1'b0, GT, 1, 0, 1'b0, 2'd0, 4'h0);
    // B = 0x8001: equal down to bit 0 -> l after 16 cycles
    load_nib(1'b1, 2'd3, 4'h8);
    do_compare("w16_lt_lsb", 1'b0, LT, 16, 0, 1'b0, 2'd0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog: the directed sequence is far shorter than this
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule

// File: doc/seq_mag_comparator.md
SEQ_MAG_COMPARATOR -- requirements
Module: seq_mag_comparator

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be a multiple of 4 in the range 4..32.
REQ-002 Parameter NSEL, default max(1, clog2(WIDTH/4)), width of the nibble-index port.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 load  input  1  level from push button; a rising edge writes Y into the selected nibble.
REQ-006 op_sel  input  1  operand select for loads: 0 = A, 1 = B.
REQ-007 nib_sel  input  NSEL  nibble index for loads; 0 = bits [3:0].
REQ-008 Y  input  4  nibble data.
REQ-009 start  input  1  level from push button; a rising edge requests a comparison.
REQ-010 signed_mode  input  1  0 = unsigned compare, 1 = two's-complement compare; sampled at start acceptance.
REQ-011 l, g, e  output  1 each  A<B, A>B, A==B; registered and one-hot once a result exists.
REQ-012 valid  output  1  single-cycle pulse marking a new l/g/e result.
REQ-013 busy  output  1  high while a comparison is in progress.

Function
REQ-014 load and start SHALL each pass through a 2-flop synchroniser followed by a registered previous-value flop; edge = sync2 & ~prev.
REQ-015 Latency: a rising edge on load or start first sampled at clk edge k SHALL take effect at clk edge k+2.
REQ-016 On a load edge, A or B (per op_sel) bits [4*nib_sel+3 : 4*nib_sel] SHALL take Y; all other bits are unchanged.
REQ-017 nib_sel >= WIDTH/4 SHALL be ignored (no write).
REQ-018 Loads SHALL be accepted in every state and SHALL NOT disturb a comparison already in progress.
REQ-019 FSM states: IDLE, CMP, DONE.
REQ-020 IDLE -> CMP on a start edge: snapshot A, B and signed_mode; set bit index i = WIDTH-1; busy = 1.
REQ-021 CMP examines one bit per cycle, MSB first.
REQ-022 CMP, bits differ at i: result is g if A[i]=1, else l; in signed mode the sense SHALL be inverted at i = WIDTH-1; go to DONE.
REQ-023 CMP, bits equal and i > 0: i decrements; remain in CMP.
REQ-024 CMP, bits equal and i = 0: result e; go to DONE.
REQ-025 l/g/e SHALL update at the CMP -> DONE edge and SHALL hold until the next result.
REQ-026 DONE SHALL assert valid for exactly one cycle, then return to IDLE; busy deasserts on that return.
REQ-027 Start-to-valid latency SHALL be m+1 cycles after the start-accept edge, where m = WIDTH-1-(first differing bit index), or WIDTH-1 if A == B.
REQ-028 Start edges arriving while busy = 1 SHALL be dropped, not queued.
REQ-029 A load edge and a start edge in the same cycle: the write occurs and the snapshot SHALL take the pre-write value.

Reset
REQ-030 reset SHALL force: state IDLE, A = B = 0, l = g = e = 0, valid = 0, busy = 0, synchroniser and previous-value flops = 0.
REQ-031 reset asserted mid-comparison SHALL abort it; no valid pulse SHALL follow.
REQ-032 After reset, a button held high SHALL NOT generate an edge until it falls and rises again.

Verification (WIDTH = 8 unless stated)
REQ-033 Load A = 0x5A and B = 0x5A as four nibble loads, then start -> e = 1; valid one cycle, 8 cycles after start accept.
REQ-034 A = 0x80, B = 0x7F, signed_mode = 0 -> g = 1 after 1 cycle; with signed_mode = 1 -> l = 1.
REQ-035 A = 0x12, B = 0x13 -> l = 1 with valid at cycle 8; second start edge during busy -> exactly one valid pulse.
REQ-036 Reset asserted in CMP at i = 4 -> all outputs 0 next cycle; no valid pulse; new start after release works.
REQ-037 Load B[7:4] = 0xF during a comparison of A = 0x00, B = 0x01 -> result l from snapshot; B reads 0xF1 afterward.
REQ-038 WIDTH = 16: A = 0x8000, B = 0x0001, signed_mode = 1 -> l = 1; nib_sel = 3 loads bits [15:12].
